// File: rtl/cfa_pkg.sv
// Shared types and constants for the CFA demosaic scan sequencer.
// Holds the sequencer states, the 5x5 window geometry and the default widths.
package cfa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        LOAD,
        UPDATE,
        ROW_END,
        DRAIN,
        DONE
    } cfa_state_e;

    localparam int WIN        = 5;
    localparam int PRIME_CYC  = 20;
    localparam int LOAD_CYC   = 5;
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DIM_W  = 11;

endpackage

// File: rtl/cfa_clamp_addr.sv
// Border-replicating read address former for one window tap.
// Row offset comes from the window slot, column offset from the scan phase.
module cfa_clamp_addr
    import cfa_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W
) (
    input  logic [DIM_W-1:0]  i_row,
    input  logic [DIM_W-1:0]  i_rowMax,
    input  logic [DIM_W-1:0]  i_col,
    input  logic [DIM_W-1:0]  i_colMax,
    input  logic [2:0]        i_slot,
    input  logic signed [2:0] i_colOff,
    input  logic [ADDR_W-1:0] i_rowBase,
    output logic [ADDR_W-1:0] o_addr
);

    localparam int SW = DIM_W + 2;
    localparam logic signed [SW-1:0] ONE  = SW'(1);
    localparam logic signed [SW-1:0] TWO  = SW'(2);
    localparam logic signed [SW-1:0] MONE = -SW'(1);
    localparam logic signed [SW-1:0] MTWO = -SW'(2);

    logic signed [SW-1:0] w_rowRaw;
    logic signed [SW-1:0] w_rowLast;
    logic signed [SW-1:0] w_rowClamp;
    logic signed [SW-1:0] w_rowDiff;
    logic signed [SW-1:0] w_colRaw;
    logic signed [SW-1:0] w_colLast;
    logic signed [SW-1:0] w_colClamp;
    logic [ADDR_W-1:0]    w_colMaxA;
    logic [ADDR_W-1:0]    w_rowDelta;

    // The clamped row is at most two rows from the current one, so the row
    // base is adjusted by +-colMax or +-2*colMax instead of multiplying.
    always_comb begin
        w_rowRaw   = $signed(SW'(i_row)) + $signed(SW'(i_slot)) - TWO;
        w_rowLast  = $signed(SW'(i_rowMax)) - ONE;
        w_rowClamp = w_rowRaw;
        if (w_rowRaw < 0) begin
            w_rowClamp = '0;
        end else if (w_rowRaw > w_rowLast) begin
            w_rowClamp = w_rowLast;
        end
        w_rowDiff = w_rowClamp - $signed(SW'(i_row));

        w_colRaw   = $signed(SW'(i_col)) + SW'(i_colOff);
        w_colLast  = $signed(SW'(i_colMax)) - ONE;
        w_colClamp = w_colRaw;
        if (w_colRaw < 0) begin
            w_colClamp = '0;
        end else if (w_colRaw > w_colLast) begin
            w_colClamp = w_colLast;
        end

        w_colMaxA  = ADDR_W'(i_colMax);
        w_rowDelta = '0;
        if (w_rowDiff == MTWO) begin
            w_rowDelta = ADDR_W'(0) - (w_colMaxA << 1);
        end else if (w_rowDiff == MONE) begin
            w_rowDelta = ADDR_W'(0) - w_colMaxA;
        end else if (w_rowDiff == ONE) begin
            w_rowDelta = w_colMaxA;
        end else if (w_rowDiff == TWO) begin
            w_rowDelta = w_colMaxA << 1;
        end

        o_addr = i_rowBase + w_rowDelta + ADDR_W'(w_colClamp);
    end

endmodule

// File: rtl/cfa_scan_sequencer.sv
// Raster-scan sequencer for the CFA demosaic datapath: streams one 5-row window
// column per pixel, steps the datapath and emits latency-matched write strobes.
module cfa_scan_sequencer
    import cfa_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DIM_W    = DEF_DIM_W,
    parameter int PIPE_LAT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  rowMax,
    input  logic [DIM_W-1:0]  colMax,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] readAddress,
    output logic              rdValid,
    output logic [2:0]        rdSlot,
    output logic              colUpdate,
    output logic              rowUpdate,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [2:0]        writeEnable
);

    // The output register is the last stage, so PIPE_LAT must be at least 2.
    localparam int STAGES = PIPE_LAT - 1;
    localparam int PHASES = PRIME_CYC / WIN;

    cfa_state_e        r_state;
    cfa_state_e        w_nextState;
    logic [DIM_W-1:0]  r_rowMax;
    logic [DIM_W-1:0]  r_colMax;
    logic [DIM_W-1:0]  r_row;
    logic [DIM_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_rowBase;
    logic [2:0]        r_slot;
    logic [1:0]        r_phase;
    logic              r_issueValid;
    logic [2:0]        r_issueSlot;
    logic [STAGES-1:0] r_wpValid;
    logic [ADDR_W-1:0] r_wpAddr [STAGES];

    logic              w_issue;
    logic signed [2:0] w_colOff;
    logic [ADDR_W-1:0] w_readAddr;
    logic [ADDR_W-1:0] w_pixAddr;
    logic              w_dimZero;
    logic              w_slotLast;
    logic              w_primeLast;
    logic              w_colLast;
    logic              w_rowLast;
    logic              w_pipeBusy;

    assign w_dimZero   = (rowMax == '0) || (colMax == '0);
    assign w_slotLast  = (r_slot == 3'(WIN - 1));
    assign w_primeLast = w_slotLast && (r_phase == 2'(PHASES - 1));
    assign w_colLast   = (r_col == r_colMax - DIM_W'(1));
    assign w_rowLast   = (r_row == r_rowMax - DIM_W'(1));
    assign w_pipeBusy  = |r_wpValid;
    assign w_pixAddr   = r_rowBase + ADDR_W'(r_col);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = w_dimZero ? DONE : PRIME;
            PRIME:   if (w_primeLast) w_nextState = LOAD;
            LOAD:    if (w_slotLast) w_nextState = UPDATE;
            UPDATE:  w_nextState = w_colLast ? ROW_END : LOAD;
            ROW_END: w_nextState = w_rowLast ? DRAIN : PRIME;
            DRAIN:   if (!w_pipeBusy) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // PRIME walks window columns c-2..c+1; LOAD always fetches column c+2.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        colUpdate = 1'b0;
        rowUpdate = 1'b0;
        w_issue   = 1'b0;
        w_colOff  = 3'sd2;
        case (r_state)
            IDLE: ;
            PRIME: begin
                busy     = 1'b1;
                w_issue  = 1'b1;
                w_colOff = $signed({1'b0, r_phase}) - 3'sd2;
            end
            LOAD: begin
                busy    = 1'b1;
                w_issue = 1'b1;
            end
            UPDATE: begin
                busy      = 1'b1;
                colUpdate = 1'b1;
            end
            ROW_END: begin
                busy      = 1'b1;
                rowUpdate = 1'b1;
            end
            DRAIN: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rowMax  <= '0;
            r_colMax  <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_rowBase <= '0;
            r_slot    <= '0;
            r_phase   <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_rowMax  <= rowMax;
                r_colMax  <= colMax;
                r_row     <= '0;
                r_col     <= '0;
                r_rowBase <= '0;
                r_slot    <= '0;
                r_phase   <= '0;
            end
            if (w_issue) begin
                r_slot <= w_slotLast ? 3'd0 : r_slot + 3'd1;
                if (r_state == PRIME && w_slotLast) begin
                    r_phase <= w_primeLast ? 2'd0 : r_phase + 2'd1;
                end
            end
            if (r_state == UPDATE) begin
                r_col <= r_col + DIM_W'(1);
            end
            if (r_state == ROW_END) begin
                r_col     <= '0;
                r_row     <= r_row + DIM_W'(1);
                r_rowBase <= r_rowBase + ADDR_W'(r_colMax);
            end
        end
    end

    cfa_clamp_addr #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_clampAddr (
        .i_row     (r_row),
        .i_rowMax  (r_rowMax),
        .i_col     (r_col),
        .i_colMax  (r_colMax),
        .i_slot    (r_slot),
        .i_colOff  (w_colOff),
        .i_rowBase (r_rowBase),
        .o_addr    (w_readAddr)
    );

    // Slot tags trail the address by one cycle to line up with memory data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readAddress  <= '0;
            r_issueValid <= 1'b0;
            r_issueSlot  <= '0;
            rdValid      <= 1'b0;
            rdSlot       <= '0;
        end else begin
            if (w_issue) begin
                readAddress <= w_readAddr;
            end
            r_issueValid <= w_issue;
            r_issueSlot  <= w_issue ? r_slot : 3'd0;
            rdValid      <= r_issueValid;
            rdSlot       <= r_issueSlot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wpValid    <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_wpAddr[i] <= '0;
            end
            writeAddress <= '0;
            writeEnable  <= '0;
        end else begin
            for (int i = STAGES - 1; i > 0; i--) begin
                r_wpValid[i] <= r_wpValid[i-1];
                r_wpAddr[i]  <= r_wpAddr[i-1];
            end
            r_wpValid[0] <= colUpdate;
            r_wpAddr[0]  <= w_pixAddr;
            writeEnable  <= {3{r_wpValid[STAGES-1]}};
            if (r_wpValid[STAGES-1]) begin
                writeAddress <= r_wpAddr[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_cfa_scan_sequencer.sv
// Directed bench for cfa_scan_sequencer: expected write addresses are queued
// when a frame is started and matched against the logged write strobes.
module tb_cfa_scan_sequencer;

    localparam int ADDR_W   = 17;
    localparam int DIM_W    = 11;
    localparam int PIPE_LAT = 6;

    typedef struct {
        int                cycle;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        en;
    } wrRec_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [DIM_W-1:0]  rowMax;
    logic [DIM_W-1:0]  colMax;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] readAddress;
    logic              rdValid;
    logic [2:0]        rdSlot;
    logic              colUpdate;
    logic              rowUpdate;
    logic [ADDR_W-1:0] writeAddress;
    logic [2:0]        writeEnable;

    int     errors = 0;
    int     checks = 0;
    int     cycleCount = 0;
    int     colCount = 0;
    int     rowCount = 0;
    int     doneCount = 0;
    int     expQ [$];
    int     updLog [$];
    wrRec_t wrLog [$];

    cfa_scan_sequencer #(
        .ADDR_W   (ADDR_W),
        .DIM_W    (DIM_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rowMax       (rowMax),
        .colMax       (colMax),
        .busy         (busy),
        .done         (done),
        .readAddress  (readAddress),
        .rdValid      (rdValid),
        .rdSlot       (rdSlot),
        .colUpdate    (colUpdate),
        .rowUpdate    (rowUpdate),
        .writeAddress (writeAddress),
        .writeEnable  (writeEnable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Event logger; all comparisons happen in the directed sequence below.
    always @(negedge clk) begin
        if (colUpdate === 1'b1) begin
            colCount++;
            updLog.push_back(cycleCount);
        end
        if (rowUpdate === 1'b1) rowCount++;
        if (done === 1'b1) doneCount++;
        if (writeEnable !== 3'b000) wrLog.push_back('{cycleCount, writeAddress, writeEnable});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int rows, input int cols);
        expQ.delete();
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                expQ.push_back(r * cols + c);
        start  = 1'b1;
        rowMax = DIM_W'(rows);
        colMax = DIM_W'(cols);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runFrame(input int rows, input int cols, input bit checkPrime, input bit disturb);
        int idx;
        int limit;
        int expDone;
        int colBase;
        int rowBase;
        int doneBase;
        int n;
        int expAddr;
        int addrBefore;
        wrRec_t rec;
        int primeExp [10] = '{0, 0, 0, 3, 6, 0, 0, 0, 3, 6};
        colBase    = colCount;
        rowBase    = rowCount;
        doneBase   = doneCount;
        addrBefore = int'(readAddress);
        wrLog.delete();
        updLog.delete();
        expDone = (rows == 0 || cols == 0) ? 0 : rows * (21 + 6 * cols) + PIPE_LAT - 1;
        limit   = expDone + 50;
        applyStimulus(rows, cols);
        idx = 0;
        while (done !== 1'b1 && idx < limit) begin
            if (checkPrime && idx >= 1 && idx <= 10)
                checkOutput("primeReadAddr", readAddress, primeExp[idx-1]);
            if (checkPrime && idx >= 2 && idx <= 11) begin
                checkOutput("primeRdValid", rdValid, 1);
                checkOutput("primeRdSlot", rdSlot, (idx - 2) % 5);
            end
            if (disturb && idx == 30) begin
                start  = 1'b1;
                rowMax = DIM_W'(7);
                colMax = DIM_W'(9);
            end
            if (disturb && idx == 31) start = 1'b0;
            @(negedge clk);
            idx++;
        end
        checkOutput("doneCycle", idx, expDone);
        checkOutput("busyAtDone", busy, 1);
        @(negedge clk);
        checkOutput("donePulseEnds", done, 0);
        checkOutput("idleAfterDone", busy, 0);
        checkOutput("donePulses", doneCount - doneBase, 1);
        checkOutput("colUpdates", colCount - colBase, rows * cols);
        checkOutput("rowUpdates", rowCount - rowBase, (cols == 0) ? 0 : rows);
        checkOutput("writeCount", wrLog.size(), expQ.size());
        if (rows == 0 || cols == 0)
            checkOutput("readAddrHeld", readAddress, addrBefore);
        else
            checkOutput("lastWriteAddr", writeAddress, rows * cols - 1);
        n = wrLog.size();
        for (int i = 0; i < n; i++) begin
            rec     = wrLog.pop_front();
            expAddr = (expQ.size() > 0) ? expQ.pop_front() : -1;
            checkOutput("writeAddr", rec.addr, expAddr);
            checkOutput("writeEn", rec.en, 3'b111);
            if (updLog.size() > 0)
                checkOutput("writeLatency", rec.cycle - updLog.pop_front(), PIPE_LAT);
        end
    endtask

    initial begin
        int doneBase;
        rst    = 1'b0;
        start  = 1'b0;
        rowMax = '0;
        colMax = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstReadAddr", readAddress, 0);
        checkOutput("rstRdValid", rdValid, 0);
        checkOutput("rstColUpdate", colUpdate, 0);
        checkOutput("rstWriteEn", writeEnable, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] zero-dimension frames");
        runFrame(0, 5, 1'b0, 1'b0);
        runFrame(4, 0, 1'b0, 1'b0);

        $display("[TB] 3x3 frame with prime-phase address check");
        runFrame(3, 3, 1'b1, 1'b0);

        $display("[TB] 3x3 frame with start and dimension changes mid-frame");
        runFrame(3, 3, 1'b0, 1'b1);

        $display("[TB] reset during row 1 of a 4x4 frame");
        applyStimulus(4, 4);
        repeat (50) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortReadAddr", readAddress, 0);
        checkOutput("abortRdValid", rdValid, 0);
        checkOutput("abortRdSlot", rdSlot, 0);
        checkOutput("abortRowUpdate", rowUpdate, 0);
        checkOutput("abortWriteAddr", writeAddress, 0);
        checkOutput("abortWriteEn", writeEnable, 0);
        wrLog.delete();
        updLog.delete();
        doneBase = doneCount;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("abortNoWrites", wrLog.size(), 0);
        checkOutput("abortNoDone", doneCount - doneBase, 0);
        checkOutput("abortIdle", busy, 0);
        runFrame(4, 4, 1'b0, 1'b0);

        $display("[TB] 70x70 frame");
        runFrame(70, 70, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
